// File: rtl/shot_controller.sv
// Turn/projectile engine for the two-tank artillery game: fire charge, ballistic flight,
// hit/miss resolution, scoring and turn hand-over. Define SHOT_WIND_EN for LFSR wind drift.
module shot_controller #(
  parameter int POWER_MAX  = 63,
  parameter int GRAVITY    = 1,
  parameter int GROUND_Y   = 384,
  parameter int SCREEN_W   = 640,
  parameter int HIT_RADIUS = 8,
  parameter int MUZZLE_DY  = 8
) (
  input  logic       clk5,
  input  logic       rst,
  input  logic       M,
  input  logic [9:0] x0_in,
  input  logic [9:0] y0_in,
  input  logic [9:0] x1_in,
  input  logic [9:0] y1_in,
  output logic       turn,
  output logic       shooting,
  output logic [9:0] shell_x,
  output logic [9:0] shell_y,
  output logic       shell_vis,
  output logic       hit,
  output logic [3:0] score0,
`ifdef SHOT_WIND_EN
  output logic [1:0] wind,
`endif
  output logic [3:0] score1
);

  typedef enum logic [2:0] {IDLE, CHARGE, LAUNCH, FLIGHT, RESOLVE} state_t;

  localparam logic signed [12:0] HR_S     = 13'(HIT_RADIUS);
  localparam logic signed [12:0] GROUND_S = 13'(GROUND_Y);
  localparam logic signed [12:0] SCRW_S   = 13'(SCREEN_W);
  localparam logic signed [10:0] MUZZLE_S = 11'(MUZZLE_DY);

  state_t             state_q, state_d;
  logic               turn_q, turn_d, shooting_q, shooting_d;
  logic               vis_q, vis_d, hit_q, hit_d, hitflag_q, hitflag_d;
  logic               m_prev_q;
  logic [10:0]        x_q, x_d;
  logic signed [10:0] sy_q, sy_d;
  logic [5:0]         power_q, power_d;
  logic [3:0]         score0_q, score0_d, score1_q, score1_d;
  logic [3:0]         vx_q, vx_d;
  logic signed [7:0]  vy_q, vy_d;

  logic               fire, hit_now, gnd_now, off_now;
  logic [9:0]         shoot_x, shoot_y, tgt_x, tgt_y;
  logic signed [10:0] launch_y;
  logic signed [12:0] step_x, wind_x, nx, ny, dxt, tgt_top;

  function automatic logic [5:0] power_sat_inc(input logic [5:0] p);
    return (p >= 6'(POWER_MAX)) ? 6'(POWER_MAX) : p + 6'd1;
  endfunction

  function automatic logic [3:0] score_sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  function automatic logic signed [7:0] vy_fall(input logic signed [7:0] v);
    logic signed [8:0] s;
    s = 9'(v) + 9'(GRAVITY);
    return (s > 9'sd31) ? 8'sd31 : 8'(s);
  endfunction

`ifdef SHOT_WIND_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] fcnt_q, fcnt_d;
  assign wind   = lfsr_q[1:0];
  assign wind_x = (fcnt_q == 3'd7) ? 13'(signed'(lfsr_q[1:0])) : 13'sd0;
`else
  assign wind_x = 13'sd0;
`endif

  // Stage boundary: combinational shot geometry on the candidate next position
  assign fire     = M & ~m_prev_q;
  assign shoot_x  = turn_q ? x1_in : x0_in;
  assign shoot_y  = turn_q ? y1_in : y0_in;
  assign tgt_x    = turn_q ? x0_in : x1_in;
  assign tgt_y    = turn_q ? y0_in : y1_in;
  assign launch_y = signed'({1'b0, shoot_y}) - MUZZLE_S;
  assign step_x   = turn_q ? -signed'({9'd0, vx_q}) : signed'({9'd0, vx_q});
  assign nx       = signed'({2'b00, x_q}) + step_x + wind_x;
  assign ny       = 13'(sy_q) + 13'(vy_q);
  assign dxt      = nx - signed'({3'b000, tgt_x});
  assign tgt_top  = signed'({3'b000, tgt_y}) - HR_S;
  assign hit_now  = (dxt >= -HR_S) && (dxt <= HR_S) && (ny >= tgt_top);
  assign gnd_now  = ny >= GROUND_S;
  assign off_now  = (nx < 13'sd0) || (!turn_q && nx >= SCRW_S);

  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    shooting_d = shooting_q;
    vis_d      = vis_q;
    hit_d      = 1'b0;
    hitflag_d  = hitflag_q;
    x_d        = x_q;
    sy_d       = sy_q;
    power_d    = power_q;
    score0_d   = score0_q;
    score1_d   = score1_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
`ifdef SHOT_WIND_EN
    lfsr_d     = lfsr_q;
    fcnt_d     = fcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        shooting_d = 1'b0;
        vis_d      = 1'b0;
        if (fire) begin
          state_d    = CHARGE;
          power_d    = '0;
          shooting_d = 1'b1;
        end
      end
      CHARGE: begin
        if (M) power_d = power_sat_inc(power_q);
        else   state_d = LAUNCH;
      end
      LAUNCH: begin
        x_d       = {1'b0, shoot_x};
        sy_d      = launch_y;
        vx_d      = 4'd1 + {1'b0, power_q[5:3]};
        vy_d      = -signed'({3'b000, power_q[5:1]});
        vis_d     = ~launch_y[10];
        hitflag_d = 1'b0;
        state_d   = FLIGHT;
`ifdef SHOT_WIND_EN
        fcnt_d    = 3'd0;
`endif
      end
      FLIGHT: begin
        x_d   = nx[10:0];
        sy_d  = ny[10:0];
        vy_d  = vy_fall(vy_q);
        vis_d = ~ny[12];
        if (hit_now || gnd_now || off_now) begin
          state_d   = RESOLVE;
          hitflag_d = hit_now;
        end
`ifdef SHOT_WIND_EN
        fcnt_d = fcnt_q + 3'd1;
`endif
      end
      RESOLVE: begin
        vis_d      = 1'b0;
        hit_d      = hitflag_q;
        if (hitflag_q && !turn_q) score0_d = score_sat_inc(score0_q);
        if (hitflag_q &&  turn_q) score1_d = score_sat_inc(score1_q);
        turn_d     = ~turn_q;
        shooting_d = 1'b0;
        state_d    = IDLE;
`ifdef SHOT_WIND_EN
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: registered control and visible shell state
  always_ff @(posedge clk5 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      turn_q     <= 1'b0;
      shooting_q <= 1'b0;
      vis_q      <= 1'b0;
      hit_q      <= 1'b0;
      hitflag_q  <= 1'b0;
      m_prev_q   <= 1'b1;
      x_q        <= '0;
      sy_q       <= '0;
      power_q    <= '0;
      score0_q   <= '0;
      score1_q   <= '0;
`ifdef SHOT_WIND_EN
      lfsr_q     <= 8'hA5;
      fcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      shooting_q <= shooting_d;
      vis_q      <= vis_d;
      hit_q      <= hit_d;
      hitflag_q  <= hitflag_d;
      m_prev_q   <= M;
      x_q        <= x_d;
      sy_q       <= sy_d;
      power_q    <= power_d;
      score0_q   <= score0_d;
      score1_q   <= score1_d;
`ifdef SHOT_WIND_EN
      lfsr_q     <= lfsr_d;
      fcnt_q     <= fcnt_d;
`endif
    end
  end

  // Velocities are pure datapath, always loaded at LAUNCH before use
  always_ff @(posedge clk5) begin
    vx_q <= vx_d;
    vy_q <= vy_d;
  end

  assign turn      = turn_q;
  assign shooting  = shooting_q;
  assign shell_x   = x_q[9:0];
  assign shell_y   = sy_q[9:0];
  assign shell_vis = vis_q;
  assign hit       = hit_q;
  assign score0    = score0_q;
  assign score1    = score1_q;

endmodule

// File: tb/tb_shot_controller.sv
// Self-checking bench for shot_controller: directed game scenarios plus randomized shots
// checked against an integer trajectory/score model.
module tb_shot_controller;
  logic       clk5 = 1'b0;
  logic       rst, M;
  logic [9:0] x0_in, y0_in, x1_in, y1_in;
  logic       turn, shooting, shell_vis, hit;
  logic [9:0] shell_x, shell_y;
  logic [3:0] score0, score1;

  int vectors = 0;
  int miscompares = 0;
  int m_turn, m_s0, m_s1;
  int mx[$], my[$];
  int cap_x[$], cap_y[$], cap_vis[$];

  always #5 clk5 = ~clk5;

  shot_controller dut (
    .clk5(clk5), .rst(rst), .M(M),
    .x0_in(x0_in), .y0_in(y0_in), .x1_in(x1_in), .y1_in(y1_in),
    .turn(turn), .shooting(shooting), .shell_x(shell_x), .shell_y(shell_y),
    .shell_vis(shell_vis), .hit(hit), .score0(score0), .score1(score1)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk5);
    #1;
  endtask

  task automatic set_pos(input int a, input int b, input int c, input int d);
    x0_in = 10'(a); y0_in = 10'(b); x1_in = 10'(c); y1_in = 10'(d);
  endtask

  // Integer reference of one shot: launch, gravity, and the three end conditions in priority
  task automatic model_shot(input int sx, input int sy, input int tx, input int ty,
                            input int pw, input bit left, output bit was_hit);
    int x, y, vx, vy;
    bit done;
    mx.delete(); my.delete();
    x = sx; y = sy - 8; vx = 1 + pw / 8; vy = -(pw / 2);
    was_hit = 1'b0; done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      x = left ? x - vx : x + vx;
      y = y + vy;
      vy = (vy + 1 > 31) ? 31 : vy + 1;
      mx.push_back(x); my.push_back(y);
      if (x - tx <= 8 && tx - x <= 8 && y >= ty - 8) begin was_hit = 1'b1; done = 1'b1; end
      else if (y >= 384) done = 1'b1;
      else if ((!left && x >= 640) || (left && x < 0)) done = 1'b1;
    end
  endtask

  task automatic run_shot(input int hold);
    int sx, sy, tx, ty, pw;
    bit left, exp_hit;
    left = (m_turn != 0);
    sx = left ? int'(x1_in) : int'(x0_in);
    sy = left ? int'(y1_in) : int'(y0_in);
    tx = left ? int'(x0_in) : int'(x1_in);
    ty = left ? int'(y0_in) : int'(y1_in);
    pw = (hold > 63) ? 63 : hold;
    model_shot(sx, sy, tx, ty, pw, left, exp_hit);
    cap_x.delete(); cap_y.delete(); cap_vis.delete();
    M = 1'b1; tick;
    vectors++;
    if (shooting !== 1'b1) begin
      $display("FAIL charge_shooting: got %b want 1", shooting); miscompares++;
    end
    repeat (hold) tick;
    M = 1'b0; tick; tick;
    vectors++;
    if (shell_x !== 10'(sx) || shell_y !== 10'(sy - 8) || shell_vis !== logic'(sy - 8 >= 0) || hit !== 1'b0) begin
      $display("FAIL launch: got (%0d,%0d,vis=%b,hit=%b) want (%0d,%0d,vis=%b,hit=0)",
               shell_x, shell_y, shell_vis, hit, 10'(sx), 10'(sy - 8), sy - 8 >= 0);
      miscompares++;
    end
    for (int k = 0; k < mx.size(); k++) begin
      tick;
      cap_x.push_back(int'(shell_x)); cap_y.push_back(int'(shell_y)); cap_vis.push_back(int'(shell_vis));
      vectors++;
      if (shell_x !== 10'(mx[k]) || shell_y !== 10'(my[k]) || shell_vis !== logic'(my[k] >= 0)
          || shooting !== 1'b1 || hit !== 1'b0) begin
        $display("FAIL flight[%0d]: got (%0d,%0d,vis=%b,sh=%b,hit=%b) want (%0d,%0d,vis=%b,sh=1,hit=0)",
                 k, shell_x, shell_y, shell_vis, shooting, hit, 10'(mx[k]), 10'(my[k]), my[k] >= 0);
        miscompares++;
      end
    end
    tick;
    if (exp_hit && !left) m_s0 = (m_s0 < 15) ? m_s0 + 1 : 15;
    if (exp_hit &&  left) m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
    m_turn = 1 - m_turn;
    vectors++;
    if (turn !== logic'(m_turn) || shooting !== 1'b0 || shell_vis !== 1'b0 || hit !== exp_hit
        || score0 !== 4'(m_s0) || score1 !== 4'(m_s1)) begin
      $display("FAIL resolve: got turn=%b sh=%b vis=%b hit=%b s0=%0d s1=%0d want turn=%0d sh=0 vis=0 hit=%b s0=%0d s1=%0d",
               turn, shooting, shell_vis, hit, score0, score1, m_turn, exp_hit, m_s0, m_s1);
      miscompares++;
    end
    tick;
    vectors++;
    if (hit !== 1'b0) begin
      $display("FAIL hit_pulse_width: got %b want 0", hit); miscompares++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; M = 1'b0;
    set_pos(200, 384, 420, 384);
    tick; tick;
    vectors++;
    if (turn !== 1'b0 || shooting !== 1'b0 || shell_x !== 10'd0 || shell_y !== 10'd0
        || shell_vis !== 1'b0 || hit !== 1'b0 || score0 !== 4'd0 || score1 !== 4'd0) begin
      $display("FAIL reset_values: got turn=%b sh=%b x=%0d y=%0d vis=%b hit=%b s0=%0d s1=%0d want all 0",
               turn, shooting, shell_x, shell_y, shell_vis, hit, score0, score1);
      miscompares++;
    end
    rst = 1'b0;
    m_turn = 0; m_s0 = 0; m_s1 = 0;
    tick;
  endtask

  task automatic test_miss;
    int ex[8], ey[8];
    ex = '{201, 202, 203, 204, 205, 206, 207, 208};
    ey = '{374, 373, 373, 374, 376, 379, 383, 388};
    set_pos(200, 384, 420, 384);
    run_shot(4);
    vectors++;
    if (cap_x.size() != 8) begin
      $display("FAIL miss_length: got %0d flight cycles want 8", cap_x.size()); miscompares++;
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (k >= cap_x.size() || cap_x[k] != ex[k] || cap_y[k] != ey[k]) begin
        $display("FAIL miss_path[%0d]: got (%0d,%0d) want (%0d,%0d)", k,
                 (k < cap_x.size()) ? cap_x[k] : -1, (k < cap_y.size()) ? cap_y[k] : -1, ex[k], ey[k]);
        miscompares++;
      end
    end
  endtask

  task automatic test_saturation;
    bit saw_hidden;
    set_pos(200, 384, 420, 384);
    run_shot(100);
    saw_hidden = 1'b0;
    foreach (cap_vis[k]) if (cap_vis[k] == 0) saw_hidden = 1'b1;
    vectors++;
    if (cap_x.size() < 1 || cap_x[0] != 412 || cap_y[0] != 345 || !saw_hidden || turn !== 1'b0) begin
      $display("FAIL sat_direction: got first=(%0d,%0d) hidden=%b turn=%b want first=(412,345) hidden=1 turn=0",
               (cap_x.size() > 0) ? cap_x[0] : -1, (cap_y.size() > 0) ? cap_y[0] : -1, saw_hidden, turn);
      miscompares++;
    end
  endtask

  task automatic test_hit;
    set_pos(200, 384, 205, 384);
    run_shot(4);
    vectors++;
    if (cap_x.size() != 5 || cap_x[4] != 205 || cap_y[4] != 376 || score0 !== 4'd1 || turn !== 1'b1) begin
      $display("FAIL hit_directed: got n=%0d last=(%0d,%0d) s0=%0d turn=%b want n=5 last=(205,376) s0=1 turn=1",
               cap_x.size(), (cap_x.size() > 0) ? cap_x[cap_x.size()-1] : -1,
               (cap_y.size() > 0) ? cap_y[cap_y.size()-1] : -1, score0, turn);
      miscompares++;
    end
  endtask

  task automatic test_reset_hold;
    set_pos(200, 384, 600, 384);
    M = 1'b1; tick;
    repeat (10) tick;
    M = 1'b0; tick; tick;
    repeat (2) tick;
    M = 1'b1; tick;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (turn !== 1'b0 || shooting !== 1'b0 || shell_x !== 10'd0 || shell_y !== 10'd0
        || shell_vis !== 1'b0 || hit !== 1'b0 || score0 !== 4'd0 || score1 !== 4'd0) begin
      $display("FAIL abort_reset: got turn=%b sh=%b x=%0d y=%0d vis=%b hit=%b s0=%0d s1=%0d want all 0",
               turn, shooting, shell_x, shell_y, shell_vis, hit, score0, score1);
      miscompares++;
    end
    tick; tick;
    rst = 1'b0;
    m_turn = 0; m_s0 = 0; m_s1 = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      vectors++;
      if (shooting !== 1'b0) begin
        $display("FAIL held_button_fired[%0d]: got shooting=%b want 0", k, shooting); miscompares++;
      end
    end
    M = 1'b0; tick;
    run_shot(3);
  endtask

  task automatic test_random;
    for (int n = 0; n < 25; n++) begin
      set_pos($urandom_range(0, 639), $urandom_range(200, 384),
              $urandom_range(0, 639), $urandom_range(200, 384));
      run_shot($urandom_range(0, 70));
    end
  endtask

  task automatic test_score_sat;
    rst = 1'b1; tick; rst = 1'b0;
    m_turn = 0; m_s0 = 0; m_s1 = 0;
    tick;
    for (int n = 0; n < 16; n++) begin
      set_pos(100, 384, 104, 384);
      run_shot(0);
      set_pos(100, 384, 600, 384);
      run_shot(0);
    end
    vectors++;
    if (score0 !== 4'd15 || score1 !== 4'd0) begin
      $display("FAIL score_saturation: got s0=%0d s1=%0d want s0=15 s1=0", score0, score1);
      miscompares++;
    end
  endtask

  initial begin
    rst = 1'b1; M = 1'b0;
    set_pos(0, 0, 0, 0);
    test_reset;
    test_miss;
    test_saturation;
    test_hit;
    test_reset_hold;
    test_random;
    test_score_sat;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
